// File: rtl/regfile_pkg.sv
// Shared defaults, types and packed-vector helpers for the regfile_mp register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 32;
    localparam int REG_ZERO       = 0;

    typedef logic [DEFAULT_DATA_W-1:0]        word_t;
    typedef logic [$clog2(DEFAULT_DEPTH)-1:0] addr_t;

    // Low bit of lane k in a vector of lanes that are w bits wide.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

    // True when an address names a real, writable register.
    function automatic logic addr_ok(input int addr, input int depth, input bit zero_reg);
        return (addr < depth) && !(zero_reg && addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port select: stored word, write-through bypass (highest write port wins), or zero.
module regfile_bypass_mux
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = DEFAULT_DATA_W,
    parameter int  DEPTH    = DEFAULT_DEPTH,
    parameter int  NUM_WR   = 1,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic [DATA_W-1:0]        i_stored,
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*AW-1:0]     i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]            i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_match
);

    logic [DATA_W-1:0] w_bypass;
    logic              w_valid;

    // NOTE: combinational logic uses blocking assignments with defaults first, so no latch is inferred.
    always_comb begin
        w_valid  = addr_ok(int'(i_rd_addr), DEPTH, ZERO_REG != 0);
        o_match  = 1'b0;
        w_bypass = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (i_wr_en[k] && w_valid && i_wr_addr[slice_lo(k, AW) +: AW] == i_rd_addr) begin
                o_match  = 1'b1;
                w_bypass = i_wr_data[slice_lo(k, DATA_W) +: DATA_W];
            end
        end
        if (!w_valid)     o_rd_data = '0;
        else if (o_match) o_rd_data = w_bypass;
        else              o_rd_data = i_stored;
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-through bypass and write-port priority.
// Optional busy scoreboard (sb_set_*, rd_busy) is built when REGFILE_SCOREBOARD_EN is defined.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = DEFAULT_DATA_W,
    parameter int  DEPTH    = DEFAULT_DEPTH,
    parameter int  NUM_RD   = 2,
    parameter int  NUM_WR   = 1,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
`ifdef REGFILE_SCOREBOARD_EN
    input  logic                     sb_set_en,
    input  logic [AW-1:0]            sb_set_addr,
    output logic [NUM_RD-1:0]        rd_busy,
`endif
    output logic [NUM_RD*DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [NUM_WR-1:0] w_wr_en;

    // Bypass is blocked while reset is low so every read port sees the cleared file.
    assign w_wr_en = wr_en & {NUM_WR{reset}};

    // NOTE: the array is reset asynchronously because the block must read zero the moment reset asserts;
    // later loop iterations override earlier ones, which gives the higher-index write port priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && addr_ok(int'(wr_addr[slice_lo(k, AW) +: AW]), DEPTH, ZERO_REG != 0))
                    r_mem[wr_addr[slice_lo(k, AW) +: AW]] <= wr_data[slice_lo(k, DATA_W) +: DATA_W];
            end
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] r_busy;

    // Clears are applied first so a same-cycle set on the same register wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && addr_ok(int'(wr_addr[slice_lo(k, AW) +: AW]), DEPTH, ZERO_REG != 0))
                    r_busy[wr_addr[slice_lo(k, AW) +: AW]] <= 1'b0;
            end
            if (sb_set_en && addr_ok(int'(sb_set_addr), DEPTH, ZERO_REG != 0))
                r_busy[sb_set_addr] <= 1'b1;
        end
    end
`endif

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [AW-1:0]     w_addr;
        logic [DATA_W-1:0] w_stored;
`ifdef REGFILE_SCOREBOARD_EN
        logic              w_match;
`else
        logic              w_match_unused;
`endif

        assign w_addr   = rd_addr[slice_lo(j, AW) +: AW];
        assign w_stored = (int'(w_addr) < DEPTH) ? r_mem[w_addr] : '0;

        regfile_bypass_mux #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_mux (
            .i_stored  (w_stored),
            .i_wr_en   (w_wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_rd_addr (w_addr),
            .o_rd_data (rd_data[slice_lo(j, DATA_W) +: DATA_W]),
`ifdef REGFILE_SCOREBOARD_EN
            .o_match   (w_match)
`else
            .o_match   (w_match_unused)
`endif
        );

`ifdef REGFILE_SCOREBOARD_EN
        assign rd_busy[j] = ((int'(w_addr) < DEPTH) ? r_busy[w_addr] : 1'b0) && !w_match;
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DEPTH=24, two write ports, two read ports).
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW  = 32;
    localparam int DEP = 24;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = $clog2(DEP);

    logic                  clk;
    logic                  reset;
    logic [NWR-1:0]        wr_en;
    logic [NWR*AW-1:0]     wr_addr;
    logic [NWR*DW-1:0]     wr_data;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DW-1:0]     rd_data;
`ifdef REGFILE_SCOREBOARD_EN
    logic                  sb_set_en;
    logic [AW-1:0]         sb_set_addr;
    logic [NRD-1:0]        rd_busy;
`endif

    int n_checks = 0;
    int n_errors = 0;

    regfile_mp #(
        .DATA_W   (DW),
        .DEPTH    (DEP),
        .NUM_RD   (NRD),
        .NUM_WR   (NWR),
        .ZERO_REG (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
`ifdef REGFILE_SCOREBOARD_EN
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .rd_busy     (rd_busy),
`endif
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_wr(input int k, input logic en, input addr_t a, input word_t d);
        wr_en[k]                = en;
        wr_addr[k*AW +: AW]     = a;
        wr_data[k*DW +: DW]     = d;
    endtask

    task automatic drive_rd(input int j, input addr_t a);
        rd_addr[j*AW +: AW] = a;
    endtask

    function automatic word_t rd(input int j);
        return rd_data[j*DW +: DW];
    endfunction

    // Commit on the rising edge, return to the falling edge for the next step.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
`ifdef REGFILE_SCOREBOARD_EN
        sb_set_en   = 1'b0;
        sb_set_addr = '0;
`endif
        drive_rd(0, 5);
        drive_rd(1, 7);
        repeat (2) @(negedge clk);
        check("reset_rd0", rd(0), 32'h0);
        check("reset_rd1", rd(1), 32'h0);

        // Preload r5, then assert reset mid-cycle with a write held.
        reset = 1'b1;
        drive_wr(0, 1'b1, 5, 32'hDEADBEEF);
        tick();
        drive_wr(0, 1'b0, 0, 32'h0);
        #1 check("preload_r5", rd(0), 32'hDEADBEEF);
        #1 reset = 1'b0;
        drive_wr(0, 1'b1, 5, 32'h11111111);
        #1 check("async_reset_r5", rd(0), 32'h0);
        tick();
        check("reset_held_write_r5", rd(0), 32'h0);
        drive_wr(0, 1'b0, 0, 32'h0);
        reset = 1'b1;
        #1 check("after_release_r5", rd(0), 32'h0);
        tick();
        check("no_commit_r5", rd(0), 32'h0);

        // Write-through on r7: bypass follows wr_en within the cycle.
        drive_wr(0, 1'b0, 7, 32'h12345678);
        #1 check("bypass_en_low", rd(1), 32'h0);
        wr_en[0] = 1'b1;
        #1 check("bypass_r7", rd(1), 32'h12345678);
        tick();
        drive_wr(0, 1'b0, 0, 32'h0);
        #1 check("stored_r7", rd(1), 32'h12345678);

        // Zero register ignores writes and bypass.
        drive_rd(0, 0);
        drive_wr(0, 1'b1, 0, 32'hFFFFFFFF);
        #1 check("r0_during_write", rd(0), 32'h0);
        tick();
        drive_wr(0, 1'b0, 0, 32'h0);
        #1 check("r0_after_write", rd(0), 32'h0);

        // Collision on r3: port 1 wins for both bypass and storage.
        drive_rd(0, 3);
        drive_rd(1, 3);
        drive_wr(0, 1'b1, 3, 32'h0000AAAA);
        drive_wr(1, 1'b1, 3, 32'h00005555);
        #1 check("collide_bypass_rd0", rd(0), 32'h00005555);
        check("collide_bypass_rd1", rd(1), 32'h00005555);
        tick();
        drive_wr(0, 1'b0, 0, 32'h0);
        drive_wr(1, 1'b0, 0, 32'h0);
        #1 check("collide_stored", rd(0), 32'h00005555);

        // Two ports to distinct registers both commit.
        drive_wr(0, 1'b1, 10, 32'h00000010);
        drive_wr(1, 1'b1, 11, 32'h00000011);
        drive_rd(0, 7);
        #1 check("unrelated_write_r7", rd(0), 32'h12345678);
        tick();
        drive_wr(0, 1'b0, 0, 32'h0);
        drive_wr(1, 1'b0, 0, 32'h0);
        drive_rd(0, 10);
        drive_rd(1, 11);
        #1 check("dual_write_r10", rd(0), 32'h00000010);
        check("dual_write_r11", rd(1), 32'h00000011);

        // Top valid register and an out-of-range address.
        drive_wr(1, 1'b1, 23, 32'h0000CAFE);
        tick();
        drive_wr(1, 1'b1, 30, 32'h00000001);
        drive_rd(0, 30);
        drive_rd(1, 23);
        #1 check("oor_bypass", rd(0), 32'h0);
        check("r23_stored", rd(1), 32'h0000CAFE);
        tick();
        drive_wr(1, 1'b0, 0, 32'h0);
        #1 check("oor_read", rd(0), 32'h0);
        check("r23_unchanged", rd(1), 32'h0000CAFE);
        drive_rd(0, 3);
        drive_rd(1, 7);
        #1 check("r3_unchanged", rd(0), 32'h00005555);
        check("r7_unchanged", rd(1), 32'h12345678);

`ifdef REGFILE_SCOREBOARD_EN
        // Scoreboard: set, bypass-clear, set-beats-clear, r0 never busy.
        drive_rd(0, 9);
        drive_rd(1, 10);
        sb_set_en   = 1'b1;
        sb_set_addr = 9;
        #1 check("sb_before_edge", word_t'(rd_busy[0]), 32'h0);
        tick();
        sb_set_en = 1'b0;
        #1 check("sb_busy_r9", word_t'(rd_busy[0]), 32'h1);
        check("sb_idle_r10", word_t'(rd_busy[1]), 32'h0);
        drive_wr(0, 1'b1, 9, 32'h00000099);
        #1 check("sb_bypass_not_busy", word_t'(rd_busy[0]), 32'h0);
        check("sb_bypass_data", rd(0), 32'h00000099);
        tick();
        drive_wr(0, 1'b0, 0, 32'h0);
        #1 check("sb_cleared", word_t'(rd_busy[0]), 32'h0);
        sb_set_en   = 1'b1;
        sb_set_addr = 9;
        drive_wr(1, 1'b1, 9, 32'h0000009A);
        tick();
        sb_set_en = 1'b0;
        drive_wr(1, 1'b0, 0, 32'h0);
        #1 check("sb_set_wins", word_t'(rd_busy[0]), 32'h1);
        drive_rd(1, 0);
        sb_set_en   = 1'b1;
        sb_set_addr = 0;
        tick();
        sb_set_en = 1'b0;
        #1 check("sb_r0_never_busy", word_t'(rd_busy[1]), 32'h0);
        reset = 1'b0;
        #1 check("sb_reset_clears", word_t'(rd_busy[0]), 32'h0);
        reset = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
